// File: rtl/cmp_sweep_checker.sv
// cmp_sweep_checker: self-test sequencer for a WIDTH-bit magnitude comparator.
// It walks every {A,B} operand pair in ascending order. Each pair is held for
// SETTLE_CYCLES cycles and then sampled for one cycle. The comparator's
// one-hot result is checked against the expected relation.
//
// Ports:
//   clk, rst_n      clock; asynchronous active-low reset
//   start           begin a sweep (accepted only in IDLE or DONE)
//   res_in[2:0]     comparator result {A<B, A==B, A>B}
//   a_out, b_out    operands driven to the comparator (idx high / low halves)
//   busy            sweep in progress (SETTLE or SAMPLE)
//   done            sweep finished; held until the next start or reset
//   pass            done with zero mismatches
//   err_count       saturating count of mismatching vectors
//   first_fail_idx  vector index of the first mismatch
module cmp_sweep_checker #(
  parameter int WIDTH         = 2,
  parameter int SETTLE_CYCLES = 1,
  parameter int ERR_W         = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2:0]           res_in,
  output logic [WIDTH-1:0]     a_out,
  output logic [WIDTH-1:0]     b_out,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_W-1:0]     err_count,
  output logic [2*WIDTH-1:0]   first_fail_idx
);

  localparam int IW = 2 * WIDTH;
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  state_t          state;
  logic [IW-1:0]   idx;
  logic [CW-1:0]   cnt;

  logic [2:0]      exp_res;
  logic            mismatch;

  // The operands are the idx register itself, so they change exactly when idx does.
  assign a_out = idx[IW-1:WIDTH];
  assign b_out = idx[WIDTH-1:0];

  // Expected one-hot relation. Any non-one-hot res_in cannot equal this value,
  // so it is always reported as a mismatch.
  assign exp_res  = {a_out < b_out, a_out == b_out, a_out > b_out};
  assign mismatch = (res_in != exp_res);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      idx            <= '0;
      cnt            <= '0;
      err_count      <= '0;
      first_fail_idx <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            idx            <= '0;
            err_count      <= '0;
            first_fail_idx <= '0;
            cnt            <= CNT_LOAD;
            state          <= SETTLE;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
          end
        end
        SETTLE: begin
          if (cnt == '0) state <= SAMPLE;
          else           cnt   <= cnt - CW'(1);
        end
        SAMPLE: begin
          if (mismatch) begin
            if (!(&err_count))     err_count      <= err_count + ERR_W'(1);
            if (err_count == '0)   first_fail_idx <= idx;
          end
          // The last vector ends the sweep, so idx never wraps back to zero.
          if (&idx) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_count == '0) && !mismatch;
          end else begin
            idx   <= idx + IW'(1);
            cnt   <= CNT_LOAD;
            state <= SETTLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_sweep_checker.sv
module tb_cmp_sweep_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  int         mode = 0;  // 0 ideal, 1 eq stuck 0, 2 gt/lt swapped, 3 bad code at A=3,B=2

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  // Three instances: defaults, narrow error counter, and longer settle time.
  logic [1:0] a0, b0, a1, b1, a2, b2;
  logic [2:0] r0, r1, r2;
  logic       busy0, done0, pass0, busy1, done1, pass1, busy2, done2, pass2;
  logic [7:0] err0, err2;
  logic [1:0] err1;
  logic [3:0] ff0, ff1, ff2;

  cmp_sweep_checker u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .res_in(r0),
    .a_out(a0), .b_out(b0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .first_fail_idx(ff0));

  cmp_sweep_checker #(.ERR_W(2)) u_dut_e2 (
    .clk(clk), .rst_n(rst_n), .start(start), .res_in(r1),
    .a_out(a1), .b_out(b1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .first_fail_idx(ff1));

  cmp_sweep_checker #(.SETTLE_CYCLES(3)) u_dut_s3 (
    .clk(clk), .rst_n(rst_n), .start(start), .res_in(r2),
    .a_out(a2), .b_out(b2), .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .first_fail_idx(ff2));

  // Comparator under test, with optional injected faults.
  function automatic logic [2:0] cmp_model(input logic [1:0] a, input logic [1:0] b, input int m);
    logic [2:0] r;
    r = {a < b, a == b, a > b};
    case (m)
      1: r = r & 3'b101;
      2: r = {r[0], r[1], r[2]};
      3: if (a == 2'd3 && b == 2'd2) r = 3'b011;
      default: ;
    endcase
    return r;
  endfunction

  always_comb begin
    r0 = cmp_model(a0, b0, mode);
    r1 = cmp_model(a1, b1, mode);
    r2 = cmp_model(a2, b2, mode);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0d want %0d", tag, got, want);
  endtask

  int done_at0, done_at1, done_at2, busy_cnt0, busy_cnt2, seq_err0, seq_err2;

  // Pulse start, then follow all instances until each reports done (bounded).
  task automatic run_sweep(input bit poke_start);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    done_at0 = 0; done_at1 = 0; done_at2 = 0;
    busy_cnt0 = 0; busy_cnt2 = 0; seq_err0 = 0; seq_err2 = 0;
    for (int c = 0; c <= 150; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        if (poke_start) start = (c == 5);
      end
      if (busy0) busy_cnt0++;
      if (busy2) busy_cnt2++;
      if (c < 32 && {a0, b0} != 4'(c / 2)) seq_err0++;
      if (c < 64 && {a2, b2} != 4'(c / 4)) seq_err2++;
      if (done0 && done_at0 == 0) done_at0 = c;
      if (done1 && done_at1 == 0) done_at1 = c;
      if (done2 && done_at2 == 0) done_at2 = c;
      if (done_at0 != 0 && done_at1 != 0 && done_at2 != 0) break;
    end
    start = 1'b0;
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_pass", pass0, 0);
    chk("rst_err", err0, 0);
    chk("rst_ab", {a0, b0}, 0);
    @(negedge clk); rst_n = 1'b1;

    // 1: ideal comparator
    mode = 0;
    run_sweep(1'b0);
    chk("t1_done_at", done_at0, 32);
    chk("t1_busy_cycles", busy_cnt0, 32);
    chk("t1_seq", seq_err0, 0);
    chk("t1_err", err0, 0);
    chk("t1_pass", pass0, 1);
    chk("t1_pass_e2", pass1, 1);
    chk("t6_done_at", done_at2, 64);
    chk("t6_busy_cycles", busy_cnt2, 64);
    chk("t6_seq", seq_err2, 0);
    chk("t6_pass", pass2, 1);

    // 2: eq stuck at 0
    mode = 1;
    run_sweep(1'b0);
    chk("t2_err", err0, 4);
    chk("t2_ffi", ff0, 0);
    chk("t2_pass", pass0, 0);
    chk("t2_done", done0, 1);
    chk("t2_err_e2", err1, 3);

    // 3: gt/lt swapped
    mode = 2;
    run_sweep(1'b0);
    chk("t3_err", err0, 12);
    chk("t3_ffi", ff0, 1);
    chk("t3_err_e2_sat", err1, 3);
    chk("t3_ffi_e2", ff1, 1);
    chk("t3_err_s3", err2, 12);

    // 4: single non-one-hot code; the restart from DONE must clear old errors
    mode = 3;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("t6_restart_err", err2, 0);
    chk("t6_restart_busy", busy2, 1);
    chk("t6_restart_done", done2, 0);
    for (int c = 0; c < 100 && !done2; c++) begin @(posedge clk); #1; end
    chk("t4_err", err0, 1);
    chk("t4_ffi", ff0, 14);
    chk("t4_pass", pass0, 0);
    chk("t4_err_s3", err2, 1);

    // 5: start while busy is ignored, then reset mid-sweep
    mode = 0;
    run_sweep(1'b1);
    chk("t5_done_at", done_at0, 32);
    chk("t5_pass", pass0, 1);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("t5_rst_busy", busy0, 0);
    chk("t5_rst_ab", {a0, b0}, 0);
    chk("t5_rst_done", done0, 0);
    chk("t5_rst_busy_s3", busy2, 0);
    @(posedge clk); #1;
    chk("t5_stays_idle", busy0, 0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("t5_no_resume", busy0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
